// File: rtl/timed_value_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tvd_pkg
// Description : Shared types and sizing constants for timed_value_driver.
//               Holds the controller state encoding and the schedule entry
//               layout at the default block configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package tvd_pkg;

  // Default configuration of the driver; the modules take their own
  // parameters and derive local widths from them.
  localparam int TVD_WIDTH = 32;
  localparam int TVD_DEPTH = 8;
  localparam int TVD_DLY_W = 8;

  localparam int CNT_W = $clog2(TVD_DEPTH + 1);
  localparam int IDX_W = $clog2(TVD_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tvd_state_e;

  // One schedule entry: wait 'delay' idle cycles, then assign 'value'.
  typedef struct packed {
    logic [TVD_DLY_W-1:0] delay;
    logic [TVD_WIDTH-1:0] value;
  } tvd_entry_t;

endpackage
`default_nettype wire

// File: rtl/timed_value_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : timed_value_driver_if
// Description : Loader / control / value-bus bundle of timed_value_driver.
//               master : loader or testbench side (offers entries, controls)
//               slave  : the driver itself
//   load_valid/load_ready/load_delay/load_value : schedule entry handshake
//   clear/start/abort                           : control strobes
//   value/value_upd/busy/done/count             : driven bus and status
// Revision    : 1.0 - initial release
// ============================================================================
interface timed_value_driver_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int DLY_W = 8
);

  logic                           load_valid;
  logic                           load_ready;
  logic [DLY_W-1:0]               load_delay;
  logic [WIDTH-1:0]               load_value;
  logic                           clear;
  logic                           start;
  logic                           abort;
  logic [WIDTH-1:0]               value;
  logic                           value_upd;
  logic                           busy;
  logic                           done;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (
    output load_valid, load_delay, load_value, clear, start, abort,
    input  load_ready, value, value_upd, busy, done, count
  );

  modport slave (
    input  load_valid, load_delay, load_value, clear, start, abort,
    output load_ready, value, value_upd, busy, done, count
  );

endinterface
`default_nettype wire

// File: rtl/timed_value_driver_table.sv
`default_nettype none
// ============================================================================
// Module      : tvd_table
// Description : DEPTH-entry schedule register file. One synchronous write
//               port, two combinational read ports: port A returns the value
//               of the entry being fired, port B the delay of the entry that
//               arms the timer next. Storage has no reset.
//   clk              : write clock
//   we/waddr         : write strobe and address
//   wdelay/wvalue    : entry written
//   raddr_a/rvalue   : value read port
//   raddr_b/rdelay   : delay read port
// Revision    : 1.0 - initial release
// ============================================================================
module tvd_table #(
  parameter int WIDTH = 32,
  parameter int DLY_W = 8,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [IDX_W-1:0] waddr,
  input  wire logic [DLY_W-1:0] wdelay,
  input  wire logic [WIDTH-1:0] wvalue,
  input  wire logic [IDX_W-1:0] raddr_a,
  output logic      [WIDTH-1:0] rvalue,
  input  wire logic [IDX_W-1:0] raddr_b,
  output logic      [DLY_W-1:0] rdelay
);

  logic [DLY_W-1:0] r_delay_mem [DEPTH];
  logic [WIDTH-1:0] r_value_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_delay_mem[waddr] <= wdelay;
      r_value_mem[waddr] <= wvalue;
    end
  end

  assign rvalue = r_value_mem[raddr_a];
  assign rdelay = r_delay_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/timed_value_driver.sv
`default_nettype none
// ============================================================================
// Module      : timed_value_driver
// Description : Scripted writer for a shared value bus. A table of
//               (delay, value) entries is loaded while idle and replayed on
//               start: each entry waits 'delay' cycles, then drives 'value'
//               with a one-cycle value_upd pulse. done pulses with the last
//               assignment. abort stops playback without firing.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : loader handshake, control strobes, value bus and status
// Revision    : 1.0 - initial release
// ============================================================================
module timed_value_driver
  import tvd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int DLY_W = 8
) (
  input wire logic             clk,
  input wire logic             rst_n,
  timed_value_driver_if.slave  bus
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tvd_state_e         r_state;
  tvd_state_e         w_state_nxt;
  logic [C_CNT_W-1:0] r_count;
  logic [C_IDX_W-1:0] r_idx;
  logic [DLY_W-1:0]   r_timer;
  logic [WIDTH-1:0]   r_value;
  logic               r_upd;
  logic               r_done;

  logic [C_IDX_W-1:0] w_rdb_idx;
  logic [DLY_W-1:0]   w_rd_delay;
  logic [WIDTH-1:0]   w_rd_value;
  logic               w_start_ok;
  logic               w_last;
  logic               w_load_ready;
  logic               w_load_fire;
  logic               w_busy;

  // clear outranks start, and an empty table cannot be started.
  assign w_start_ok  = bus.start && !bus.clear && (r_count != '0);
  assign w_last      = ((C_CNT_W'(r_idx) + C_CNT_W'(1)) == r_count);
  assign w_load_fire = bus.load_valid && w_load_ready;

  // Port B feeds the timer: entry 0 when starting, the following entry
  // while running. It is only consumed when idx+1 < count.
  assign w_rdb_idx = (r_state == RUN) ? (r_idx + C_IDX_W'(1)) : '0;

  tvd_table #(
    .WIDTH (WIDTH),
    .DLY_W (DLY_W),
    .DEPTH (DEPTH),
    .IDX_W (C_IDX_W)
  ) u_table (
    .clk     (clk),
    .we      (w_load_fire),
    .waddr   (r_count[C_IDX_W-1:0]),
    .wdelay  (bus.load_delay),
    .wvalue  (bus.load_value),
    .raddr_a (r_idx),
    .rvalue  (w_rd_value),
    .raddr_b (w_rdb_idx),
    .rdelay  (w_rd_delay)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over a fire due in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if ((r_timer == '0) && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_busy       = (r_state == RUN);
    w_load_ready = (r_state == IDLE) && (r_count < C_CNT_W'(DEPTH)) &&
                   !bus.start && !bus.clear;
  end

  // Counters, timer and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_value <= '0;
      r_upd   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_upd  <= 1'b0;
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.clear) begin
          r_count <= '0;
        end else if (w_start_ok) begin
          r_idx   <= '0;
          r_timer <= w_rd_delay;
        end else if (w_load_fire) begin
          r_count <= r_count + C_CNT_W'(1);
        end
      end else begin
        if (bus.abort) begin
          r_idx <= '0;
        end else if (r_timer != '0) begin
          r_timer <= r_timer - DLY_W'(1);
        end else begin
          r_value <= w_rd_value;
          r_upd   <= 1'b1;
          if (w_last) begin
            r_done <= 1'b1;
            r_idx  <= '0;
          end else begin
            r_idx   <= r_idx + C_IDX_W'(1);
            r_timer <= w_rd_delay;
          end
        end
      end
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.value      = r_value;
  assign bus.value_upd  = r_upd;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_timed_value_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_timed_value_driver
// Description : Self-checking bench for timed_value_driver. Expected fires
//               (edge number, value, last flag) are queued when playback is
//               started and popped by a monitor on every value_upd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timed_value_driver;
  import tvd_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  timed_value_driver_if #(
    .WIDTH (TVD_WIDTH),
    .DEPTH (TVD_DEPTH),
    .DLY_W (TVD_DLY_W)
  ) bus ();

  timed_value_driver #(
    .WIDTH (TVD_WIDTH),
    .DEPTH (TVD_DEPTH),
    .DLY_W (TVD_DLY_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int                   cyc;
    logic [TVD_WIDTH-1:0] val;
    bit                   last;
  } exp_t;

  exp_t       sb[$];
  tvd_entry_t mdl[TVD_DEPTH];
  int         mdl_n      = 0;
  int         n_chk      = 0;
  int         n_err      = 0;
  int         cyc        = 0;
  int         n_upd      = 0;
  int         cons_stage = 0;
  bit         cons_arm   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Consumer predicates, satisfied in order.
  function automatic bit pred(input int stage, input logic [TVD_WIDTH-1:0] v);
    case (stage)
      0:       return (v == 2);
      1:       return (v < 2);
      2:       return (v == 0);
      default: return (v > 1) && (v < 3);
    endcase
  endfunction

  // Fire monitor and scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.value_upd) begin
        n_upd++;
        if (sb.size() == 0) begin
          chk_eq("unexp_upd", bus.value_upd, 0);
        end else begin
          e = sb.pop_front();
          chk_eq("fire_value", bus.value, e.val);
          chk_eq("fire_cycle", cyc, e.cyc);
          chk_eq("done_at_fire", bus.done, e.last);
        end
      end else if (bus.done) begin
        chk_eq("stray_done", bus.done, 0);
      end
      if (cons_arm) begin
        while (cons_stage < 4 && pred(cons_stage, bus.value)) cons_stage++;
      end
    end
  end

  task automatic load_entry(input logic [TVD_DLY_W-1:0] d, input logic [TVD_WIDTH-1:0] v);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_delay = d;
    bus.load_value = v;
    #1;
    chk_eq("load_ready", bus.load_ready, (mdl_n < TVD_DEPTH));
    if (mdl_n < TVD_DEPTH) begin
      mdl[mdl_n] = '{delay: d, value: v};
      mdl_n++;
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.abort      = 1'b0;
  endtask

  task automatic clear_tbl();
    @(negedge clk);
    bus.clear = 1'b1;
    mdl_n     = 0;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Start playback; queue the first nexp fires. e = edge that accepts start.
  task automatic play(input int nexp, output int e);
    int t;
    @(negedge clk);
    bus.start = 1'b1;
    e = cyc + 1;
    t = e;
    for (int i = 0; i < mdl_n; i++) begin
      t = t + int'(mdl[i].delay) + 1;
      if (i < nexp) sb.push_back('{cyc: t, val: mdl[i].value, last: (i == mdl_n - 1)});
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy && sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk_eq("drain_timeout", sb.size(), 0);
    chk_eq("busy_end", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int e;
    int u0;
    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_delay = '0;
    bus.load_value = '0;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_value", bus.value, 0);
    chk_eq("rst_upd", bus.value_upd, 0);
    chk_eq("rst_done", bus.done, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_count", bus.count, 0);
    chk_eq("rst_load_ready", bus.load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Scheduler script with a predicate-waiting consumer
    load_entry(8'd1, 32'd1);
    load_entry(8'd0, 32'd2);
    load_entry(8'd0, 32'd0);
    load_entry(8'd0, 32'd2);
    idle_in();
    chk_eq("script_count", bus.count, 4);
    cons_stage = 0;
    cons_arm   = 1'b1;
    u0         = n_upd;
    play(4, e);
    wait_done(50);
    chk_eq("script_upd_pulses", n_upd - u0, 4);
    chk_eq("consumer_done", cons_stage, 4);
    chk_eq("script_value", bus.value, 2);
    cons_arm = 1'b0;

    // Full table: DEPTH+1 back-to-back offers, last one refused
    clear_tbl();
    #1;
    chk_eq("clear_count", bus.count, 0);
    for (int i = 0; i <= TVD_DEPTH; i++) load_entry(8'd0, 32'd100 + 32'(i));
    idle_in();
    chk_eq("full_count", bus.count, TVD_DEPTH);
    play(TVD_DEPTH, e);
    wait_done(50);
    chk_eq("full_last_value", bus.value, 32'd100 + 32'(TVD_DEPTH - 1));

    // Start with an empty table is ignored
    clear_tbl();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk_eq("empty_start_busy", bus.busy, 0);
    @(negedge clk);
    #1;
    chk_eq("empty_start_busy2", bus.busy, 0);
    chk_eq("empty_start_value", bus.value, 32'd100 + 32'(TVD_DEPTH - 1));

    // Abort on the cycle entry 1 would fire
    load_entry(8'd3, 32'd7);
    load_entry(8'd3, 32'd9);
    idle_in();
    play(1, e);
    while (cyc < e + 7) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk_eq("abort_busy", bus.busy, 0);
    chk_eq("abort_done", bus.done, 0);
    chk_eq("abort_value", bus.value, 7);
    chk_eq("abort_count", bus.count, 2);
    chk_eq("abort_sb", sb.size(), 0);
    repeat (10) @(negedge clk);
    play(2, e);
    wait_done(50);
    chk_eq("replay_value", bus.value, 9);

    // Maximum delay on a single entry
    clear_tbl();
    load_entry({TVD_DLY_W{1'b1}}, 32'hA5);
    idle_in();
    play(1, e);
    wait_done(400);
    chk_eq("maxdly_value", bus.value, 32'hA5);

    // clear + start together in IDLE: clear wins; load_ready low under start
    clear_tbl();
    load_entry(8'd0, 32'h55);
    idle_in();
    @(negedge clk);
    bus.clear      = 1'b1;
    bus.start      = 1'b1;
    bus.load_valid = 1'b1;
    #1;
    chk_eq("ready_under_start", bus.load_ready, 0);
    mdl_n = 0;
    idle_in();
    #1;
    chk_eq("clr_start_count", bus.count, 0);
    chk_eq("clr_start_busy", bus.busy, 0);

    // start/clear strobed during RUN are ignored
    load_entry(8'd2, 32'd5);
    load_entry(8'd2, 32'd6);
    idle_in();
    play(2, e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    wait_done(50);
    chk_eq("run_ignore_count", bus.count, 2);

    // Asynchronous reset in the middle of playback
    clear_tbl();
    load_entry(8'd10, 32'd3);
    load_entry(8'd10, 32'd4);
    idle_in();
    play(2, e);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async_value", bus.value, 0);
    chk_eq("async_busy", bus.busy, 0);
    chk_eq("async_count", bus.count, 0);
    sb.delete();
    mdl_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    load_entry(8'd0, 32'h11);
    idle_in();
    play(1, e);
    wait_done(50);
    chk_eq("post_rst_value", bus.value, 32'h11);
    chk_eq("post_rst_count", bus.count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timed_value_driver.md
Name: timed_value_driver

Overview:
- Scripted writer for a shared value bus: plays a programmed schedule of (delay, value) entries onto `value` and pulses `value_upd` on every assignment.
- It is the producer counterpart of the condition-waiting consumers in the scheduler tests. Those consumers block until `value` satisfies a predicate, for example `==2`, `<2`, or `>1 && <3`.
- Sits between a testbench/loader and any number of waiting consumers.
- The table is loaded while idle, then replayed on `start`. It can be replayed repeatedly without reloading.

Parameters:
- WIDTH, 32, width of `value` and of each table value.
- DEPTH, 8, number of schedule entries (≥1).
- DLY_W, 8, width of each entry's delay field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  schedule entry offered.
- load_ready  out  1  entry can be accepted.
- load_delay  in  DLY_W  idle cycles before this entry's assignment.
- load_value  in  WIDTH  value to assign.
- clear  in  1  empty the table (effective only in IDLE).
- start  in  1  begin playback (effective only in IDLE).
- abort  in  1  stop playback (effective only in RUN).
- value  out  WIDTH  driven shared value.
- value_upd  out  1  one-cycle pulse: `value` changed at this edge.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on the final assignment.
- count  out  $clog2(DEPTH+1)  number of loaded entries.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE, count=0, idx=0, timer=0.
  - `value`=0, `value_upd`=0, `done`=0, `busy`=0.
  - Table contents are don't-care.
- States: IDLE, RUN.
- Loading, IDLE only:
  - `load_ready` = IDLE && count<DEPTH && !start && !clear.
  - An entry is written at table[count] and count increments on `load_valid && load_ready`.
  - When full, `load_ready`=0 and offered entries are held by the loader, never dropped.
- Clear:
  - In IDLE with `clear`=1, count becomes 0 next edge.
  - `clear` has priority over `start`.
  - `clear` is ignored in RUN.
- Start:
  - In IDLE with `start`=1, !`clear` and count>0: state becomes RUN, idx=0, timer=table[0].delay.
  - `start` with count=0 is ignored and the block stays IDLE.
  - `start` in RUN is ignored.
- RUN, per cycle:
  - If timer≠0, timer decrements.
  - If timer==0, the entry fires at this edge:
    - `value` takes table[idx].value and `value_upd`=1 for one cycle.
    - If idx==count-1: `done`=1 for one cycle, state becomes IDLE, idx=0.
    - Otherwise idx increments and timer=table[idx+1].delay.
- Timing:
  - With start accepted at edge E, entry 0 fires at edge E+d0+1.
  - Entry i fires d_i+1 edges after entry i-1.
  - Delay 0 means the adjacent edge.
- `value_upd` pulses on every fire, even if the new value equals the old one.
- Abort:
  - In RUN, `abort`=1 sets state to IDLE next edge with no fire that cycle (abort beats fire).
  - `value` is held, the table and count are retained, idx=0.
  - `done` does not pulse.
- `busy` = (state==RUN).
- `value`, `value_upd` and `done` are registered outputs with no combinational path from inputs.
- Table storage is plain registers, with no reset on the data.
- Reset asserted mid-RUN returns everything to the reset values immediately (asynchronous).

Decomposition:
- Package tvd_pkg:
  - state enum tvd_state_e {IDLE, RUN}.
  - Packed struct tvd_entry_t {delay, value}, parameterised by the localparams below.
  - Localparams CNT_W = $clog2(DEPTH+1) and IDX_W = $clog2(DEPTH).
- Optional sub-module tvd_table: DEPTH×entry register file with synchronous write port and combinational read by idx. The FSM, timer and outputs stay in the top module.

Test Plan:
- Scheduler script:
  - Load (1,1),(0,2),(0,0),(0,2) and start at edge 0.
  - Required: `value`=1 at edge 2, 2 at edge 3, 0 at edge 4, 2 at edge 5; 4 `value_upd` pulses; `done` at edge 5.
  - A consumer waiting for `==2`, `<2`, `==0` and `>1&&<3` in sequence completes.
- Full and empty:
  - Offer DEPTH+1 entries back-to-back. Required: `load_ready` drops after DEPTH accepts, count=DEPTH, and entry DEPTH+1 is not written.
  - `start` with count=0: busy stays 0 and `value` stays unchanged.
- Abort versus fire:
  - Script (3,7),(3,9); assert `abort` on the cycle entry 1 would fire.
  - Required: `value` stays 7, no second `value_upd`, no `done`, state IDLE, count=2.
  - Restart then replays 7 then 9.
- Max delay:
  - Single entry (2^DLY_W-1, 0xA5).
  - Required: fire exactly 2^DLY_W edges after start, `value`=0xA5, `done` coincident with `value_upd`.
- Priority and ignores:
  - `clear` and `start` together in IDLE: count becomes 0 and no RUN.
  - `start` and `clear` pulsed during RUN: ignored, and the sequence completes unchanged.
  - `load_ready`=0 whenever `start`=1.
- Async reset mid-RUN:
  - Drop `rst_n` between edges with no clock edge.
  - Required: `value`=0, `busy`=0, count=0 immediately; no `value_upd` or `done` after release until the table is reloaded and started.
